// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the iterative inverse cipher.
// Holds the block/key widths, the round count, the inverse S-box table,
// the FSM state type and a table-driven InvSubBytes function.
package aes_pkg;

  localparam int unsigned NR      = 10;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned KEY_W   = 128;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal,
    StDone
  } state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte-wise table lookup; purely combinational, maps to LUT logic.
  function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: row r of the column-major state is rotated right by r
// byte positions. Byte k of the block sits at [127-8k -: 8], state s[r][c]
// is byte r+4c.
//   blk     - input state
//   shifted - permuted state
module inv_shift_rows
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] blk,
  output logic [BLOCK_W-1:0] shifted
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      // s'[r][(c+r) mod 4] = s[r][c]
      assign shifted[127 - 8*(r + 4*((c + r) % 4)) -: 8] = blk[127 - 8*(r + 4*c) -: 8];
    end
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys are fetched from an external key store: rk_idx selects the key
// and rk_data must return it combinationally in the same cycle.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - ciphertext handshake, in_data is the ciphertext
//   rk_idx/rk_data      - round key request/response
//   out_valid/out_ready - plaintext handshake, out_data is the plaintext
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic [3:0]         rk_idx,
  input  logic [KEY_W-1:0]   rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data
);

  localparam logic [3:0] RkLast = 4'(NR);

  state_e             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] subbed;
  logic [BLOCK_W-1:0] round_res;
  logic [BLOCK_W-1:0] final_res;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Each column is multiplied by the circulant matrix {0e,0b,0d,09}.
  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        a[k]  = s[127 - 8*(k + 4*c) -: 8];
        x2    = xtime(a[k]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[k] = x8 ^ a[k];
        mb[k] = x8 ^ x2 ^ a[k];
        md[k] = x8 ^ x4 ^ a[k];
        me[k] = x8 ^ x4 ^ x2;
      end
      r[127 - 32*c      -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[127 - 32*c - 8  -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[127 - 32*c - 16 -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[127 - 32*c - 24 -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return r;
  endfunction

  inv_shift_rows u_inv_shift_rows (
    .blk     (data_q),
    .shifted (shifted)
  );

  assign subbed    = inv_sub_bytes(shifted);
  assign final_res = subbed ^ rk_data;
  assign round_res = inv_mix_columns(final_res);
  assign out_data  = data_q;

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = RkLast;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data ^ rk_data;
          round_d = RkLast - 4'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        rk_idx = round_q;
        data_d = round_res;
        if (round_q == 4'd1) begin
          round_d = 4'd0;
          state_d = StFinal;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      StFinal: begin
        rk_idx  = 4'd0;
        data_d  = final_res;
        state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors. The round
// key store is modelled here: a forward S-box is derived from GF(2^8)
// inverses plus the affine map, and the key schedule is expanded from it.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  localparam logic [127:0] KeyA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtA  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtA  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk_a [11];
  logic [127:0] rk_b [11];
  bit           key_sel;

  aes_inv_cipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rk_data = '0;
    if (rk_idx <= 4'd10) rk_data = key_sel ? rk_b[rk_idx] : rk_a[rk_idx];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key, input bit which);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) begin
      if (which) rk_b[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      else       rk_a[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!in_ready && k < 40) begin
      step();
      k++;
    end
    check({tag, " wait_ready"}, in_ready, 1'b1);
  endtask

  // Offers ct on the next edge; returns the cycle stamp of that edge.
  task automatic accept(input string tag, input logic [127:0] ct, input bit keep,
                        output int at);
    check({tag, " in_ready_pre"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = ct;
    step();
    at = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  // Follows the block until out_valid; checks rk_idx 9..0 and in_ready=0.
  task automatic run_rounds(input string tag, input bit junk, output int lat);
    int n = 0;
    while (!out_valid && n < 30) begin
      check({tag, " rk_idx"}, rk_idx, (n <= 9) ? 128'(9 - n) : 128'd99);
      check({tag, " in_ready_busy"}, in_ready, 1'b0);
      if (junk) in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      n++;
    end
    lat = n;
  endtask

  task automatic check_done(input string tag, input logic [127:0] pt, input int lat);
    check({tag, " latency"}, 128'(lat), 128'd10);
    check({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " rk_idx_done"}, rk_idx, 4'd10);
    check({tag, " in_ready_done"}, in_ready, 1'b0);
    check({tag, " out_data"}, out_data, pt);
  endtask

  task automatic check_exit(input string tag);
    step();
    check({tag, " out_valid_exit"}, out_valid, 1'b0);
    check({tag, " in_ready_exit"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int at1;
    int at2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    key_sel   = 1'b0;
    build_sbox();
    expand(KeyA, 1'b0);
    expand(KeyB, 1'b1);

    // Reset state
    #3;
    check("rst out_valid", out_valid, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst rk_idx", rk_idx, 4'd10);
    check("rst out_data", out_data, '0);
    #19 rst_n = 1'b1;
    step();

    // FIPS-197 C.1
    wait_ready("c1");
    accept("c1", CtA, 1'b0, at1);
    run_rounds("c1", 1'b0, lat);
    check_done("c1", PtA, lat);
    check_exit("c1");

    // FIPS-197 B, including rk_idx=10 before acceptance
    key_sel = 1'b1;
    wait_ready("b");
    check("b rk_idx_idle", rk_idx, 4'd10);
    accept("b", CtB, 1'b0, at1);
    run_rounds("b", 1'b0, lat);
    check_done("b", PtB, lat);
    check_exit("b");

    // Backpressure: 20 cycles without out_ready
    key_sel   = 1'b0;
    out_ready = 1'b0;
    wait_ready("bp");
    accept("bp", CtA, 1'b0, at1);
    run_rounds("bp", 1'b0, lat);
    check_done("bp", PtA, lat);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp hold out_valid", out_valid, 1'b1);
      check("bp hold out_data", out_data, PtA);
      check("bp hold in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    check_exit("bp");

    // in_valid held with changing data while busy
    wait_ready("busy");
    accept("busy", CtA, 1'b1, at1);
    run_rounds("busy", 1'b1, lat);
    check_done("busy", PtA, lat);
    key_sel = 1'b1;
    in_data = CtB;
    step();
    accept("busy2", CtB, 1'b0, at2);
    run_rounds("busy2", 1'b0, lat);
    check_done("busy2", PtB, lat);
    check_exit("busy2");

    // Reset during round 5
    key_sel = 1'b0;
    wait_ready("mid");
    accept("mid", CtA, 1'b0, at1);
    repeat (4) step();
    check("mid rk_idx_r5", rk_idx, 4'd5);
    rst_n = 1'b0;
    #1;
    check("mid rst in_ready", in_ready, 1'b1);
    check("mid rst rk_idx", rk_idx, 4'd10);
    check("mid rst out_data", out_data, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check("mid no out_valid", out_valid, 1'b0);
    end
    wait_ready("mid2");
    accept("mid2", CtA, 1'b0, at1);
    run_rounds("mid2", 1'b0, lat);
    check_done("mid2", PtA, lat);
    check_exit("mid2");

    // Back-to-back with out_ready held high
    key_sel = 1'b0;
    wait_ready("b2b");
    accept("b2b_a", CtA, 1'b0, at1);
    run_rounds("b2b_a", 1'b0, lat);
    check_done("b2b_a", PtA, lat);
    key_sel = 1'b1;
    step();
    accept("b2b_b", CtB, 1'b0, at2);
    check("b2b spacing", 128'(at2 - at1), 128'd12);
    run_rounds("b2b_b", 1'b0, lat);
    check_done("b2b_b", PtB, lat);
    check_exit("b2b_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: ciphertext offered.
REQ-004 SHALL have port in_ready, output, 1 bit: core can accept a ciphertext.
REQ-005 SHALL have port in_data, input, 128 bits: ciphertext. Byte 0 is [127:120]; bytes are column-major, state s[r][c] = byte r+4c.
REQ-006 SHALL have port rk_idx, output, 4 bits: index (0..10) of the requested round key.
REQ-007 SHALL have port rk_data, input, 128 bits: round key for rk_idx, valid combinationally in the same cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: plaintext available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the plaintext.
REQ-010 SHALL have port out_data, output, 128 bits: plaintext, same byte order as in_data.

Function
REQ-011 SHALL implement AES-128 inverse cipher (FIPS-197 Sec. 5.3), iterating one round per clock.
REQ-012 SHALL use FSM states IDLE, ROUND, FINAL, DONE.
REQ-013 IDLE: in_ready=1, rk_idx=10. On in_valid&&in_ready: state_reg <= in_data ^ rk_data, round <= 9, go to ROUND.
REQ-014 ROUND: rk_idx=round. state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_data). If round==1, go to FINAL; otherwise decrement round.
REQ-015 FINAL: rk_idx=0. state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk_data; go to DONE.
REQ-016 DONE: out_valid=1, out_data=state_reg, held stable. On out_ready, go to IDLE.
REQ-017 Latency: out_valid SHALL rise exactly 10 clocks after the accepting edge.
REQ-018 in_ready SHALL be 0 in ROUND, FINAL and DONE. No input is accepted during the DONE-to-IDLE exit cycle, so throughput is at most 1 block per 12 cycles.
REQ-019 in_valid SHALL be ignored outside IDLE; in_data is sampled only on the accepting edge.
REQ-020 rk_idx SHALL be 10 in DONE, so a round key is always driven.
REQ-021 InvShiftRows: row r rotates right by r bytes (s'[r][(c+r) mod 4] = s[r][c]).
REQ-022 InvMixColumns SHALL use coefficients {0e,0b,0d,09} with GF(2^8) reduction polynomial 0x11B.
REQ-023 out_data SHALL equal state_reg in every state; its value is meaningful only while out_valid=1.

Reset
REQ-024 While rst_n=0, in all states including mid-operation: FSM=IDLE, round=0, state_reg=0, out_valid=0, in_ready=1 after release, rk_idx=10.
REQ-025 A block in flight at reset SHALL be discarded, with no out_valid pulse produced.

Structure
REQ-026 The shared package aes_pkg SHALL hold the 256-entry inverse S-box constant, NR=10, and the block/key width constants.
REQ-027 Inverse byte substitution SHALL be instantiated as a pure function of the package table; no RAM.
REQ-028 One combinational sub-module, inv_shift_rows (128-bit in, 128-bit out), SHALL be instantiated. InvMixColumns SHALL be a local function.

Verification
REQ-029 The bench SHALL cover FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid 10 cycles after acceptance.
REQ-030 The bench SHALL cover FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734. It SHALL check the rk_idx sequence 10,9,...,1,0.
REQ-031 The bench SHALL cover backpressure: out_ready held 0 for 20 cycles -> out_valid and out_data stable, and in_ready=0 throughout. The block SHALL complete on the first out_ready.
REQ-032 The bench SHALL cover input during busy: in_valid held 1 with a changing in_data through a decrypt -> only the first block is decrypted, and the next is accepted in IDLE.
REQ-033 The bench SHALL cover reset mid-operation: rst_n pulsed low during round 5 -> out_valid never asserts, and a fresh C.1 vector then decrypts correctly.
REQ-034 The bench SHALL cover back-to-back operation: two vectors with out_ready=1 -> both correct, with acceptances 12 cycles apart.
